reg_update_scheduler: RTL
=========================

// Module: reg_update_scheduler
// PURPOSE
//   Collects register-write requests from two requesters (port 0: SPI command decoder; port 1: on-chip
//   demo/animation sequencer), queues them in a small FIFO and drains them into the live register bank
//   one write per clock, only inside the vertical-blank window (or at once in immediate mode).
//   Sits between the SPI/demo sources and the register bank; replaces per-register shadow copies.
// PARAMETERS
//   ADDR_W     4   register address width (matches 4-bit SPI command code)
//   DATA_W     12  write data width (widest register payload)
//   DEPTH      4   FIFO entries; power of 2, >=2
//   DRAIN_MAX  4   max writes issued per vblank window; 1..DEPTH
// PORTS
//   clk            in   1       system clock (single clock domain)
//   reset          in   1       synchronous, active-high
//   i_req0_valid   in   1       port 0 (SPI) write request
//   i_req0_addr    in   ADDR_W  port 0 register address
//   i_req0_data    in   DATA_W  port 0 data
//   o_req0_ready   out  1       port 0 accepted this cycle when valid&ready
//   i_req1_valid   in   1       port 1 (demo) write request
//   i_req1_addr    in   ADDR_W  port 1 register address
//   i_req1_data    in   DATA_W  port 1 data
//   o_req1_ready   out  1       port 1 accepted this cycle when valid&ready
//   i_vblank_start in   1       1-clk pulse at first line of vertical blank
//   i_vblank       in   1       level, high for whole vertical blank
//   i_immediate    in   1       1 = drain whenever non-empty, ignore vblank
//   o_wr_en        out  1       register-bank write strobe (registered)
//   o_wr_addr      out  ADDR_W  register-bank address (registered)
//   o_wr_data      out  DATA_W  register-bank data (registered)
//   o_pending      out  $clog2(DEPTH)+1  FIFO occupancy
//   o_full         out  1       FIFO full
// BEHAVIOUR
//   Reset: FIFO emptied, o_pending=0, o_full=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, FSM=IDLE,
//     rr_last=1 (port 0 wins first tie), drain counter=0. Reset mid-drain discards queued writes.
//   Accept: at most one push per clock. full = registered count==DEPTH; no push when full, even if a pop
//     occurs that cycle. ready is combinational from full/valid/rr_last, never from data.
//     Both valid & !full: grant port != rr_last, then rr_last <= granted port. One valid: it wins.
//     Full: both ready=0 (backpressure; requester holds valid/addr/data stable).
//   FIFO: in-order; entry = {addr,data}; push and pop in the same cycle allowed when 0<count<DEPTH
//     (count unchanged). Wrap-around of read/write pointers modulo DEPTH.
//   FSM IDLE: if i_immediate & !empty -> IMM. Else if i_vblank_start & !empty -> DRAIN, drain_cnt<=0.
//   FSM DRAIN: pop one entry per clock while i_vblank & !empty & drain_cnt<DRAIN_MAX; drain_cnt++.
//     -> IDLE when empty, i_vblank low, or drain_cnt==DRAIN_MAX. Leftovers wait for next vblank_start.
//     i_vblank_start while in DRAIN: ignored (no counter reset).
//   FSM IMM: pop one per clock while !empty; no DRAIN_MAX limit; -> IDLE when empty or i_immediate low.
//   Write port: entry popped in cycle N -> o_wr_en=1 with its addr/data in cycle N+1; o_wr_en=0 otherwise,
//     addr/data hold last value. Min latency accept->write: 2 clocks (IMM, empty FIFO).
//   No address decode: out-of-range addresses are written; bank ignores them.
//   Same-address writes are not coalesced; bank sees both, last wins.
// STRUCTURE
//   Shared header: register address constants (sky, floor, leak, other, vshift, vinf), ADDR_W/DATA_W
//     defaults; `RGB macro stays in helpers.v.
//   Sub-module: sync_fifo (param WIDTH, DEPTH; push/pop/full/empty/count), reusable elsewhere.
//   Top: round-robin arbiter, 3-state FSM, drain counter, output register.
// TESTING
//   1 Reset, port0 writes addr 0 data 0x015 while i_vblank=0 -> no o_wr_en; pulse vblank_start (vblank=1)
//     -> o_wr_en one clk, addr 0, data 0x015, 2 clks after pulse; o_pending 1->0.
//   2 Both ports valid every clk from reset, FIFO drained in IMM -> grants alternate 0,1,0,1; first is port 0.
//   3 Push 5 writes with DEPTH=4, no vblank -> 4 accepted, o_full=1, 5th held (ready=0) until a pop,
//     then accepted; order preserved on write port.
//   4 DRAIN_MAX=2, 4 queued, vblank_start -> exactly 2 writes this frame, 2 on next vblank_start.
//   5 4 queued, i_vblank falls after 1st pop -> 1 write, o_pending=3, FSM IDLE; vblank_start mid-drain
//     does not extend the count.
//   6 Reset asserted during DRAIN with 3 queued -> next clk o_wr_en=0, o_pending=0, no further writes.

Source files
------------

// File: rtl/reg_update_scheduler_pkg.sv
// rtl/reg_update_scheduler_pkg.sv - shared register map, width defaults and scheduler state type
package reg_update_scheduler_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 12;

   // live register bank addresses, numbered as the 4-bit SPI command codes
   localparam logic [ADDR_W_DEF-1:0] REG_SKY    = 4'd0;
   localparam logic [ADDR_W_DEF-1:0] REG_FLOOR  = 4'd1;
   localparam logic [ADDR_W_DEF-1:0] REG_LEAK   = 4'd2;
   localparam logic [ADDR_W_DEF-1:0] REG_OTHER  = 4'd3;
   localparam logic [ADDR_W_DEF-1:0] REG_VSHIFT = 4'd4;
   localparam logic [ADDR_W_DEF-1:0] REG_VINF   = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_IMM   = 2'd2
   } sched_state_t;

endpackage

// File: rtl/reg_update_scheduler_sync_fifo.sv
// rtl/reg_update_scheduler_sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // full is taken from the registered count, so a same-cycle pop never frees a slot early
   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // pointer and occupancy update; pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // storage array; contents are don't-care until written, so it carries no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/reg_update_scheduler.sv
// rtl/reg_update_scheduler.sv - two-port register write queue drained in vblank or immediately
module reg_update_scheduler
   import reg_update_scheduler_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH     = 4,
   parameter int DRAIN_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_req0_valid,
   input  logic [ADDR_W-1:0]      i_req0_addr,
   input  logic [DATA_W-1:0]      i_req0_data,
   output logic                   o_req0_ready,
   input  logic                   i_req1_valid,
   input  logic [ADDR_W-1:0]      i_req1_addr,
   input  logic [DATA_W-1:0]      i_req1_data,
   output logic                   o_req1_ready,
   input  logic                   i_vblank_start,
   input  logic                   i_vblank,
   input  logic                   i_immediate,
   output logic                   o_wr_en,
   output logic [ADDR_W-1:0]      o_wr_addr,
   output logic [DATA_W-1:0]      o_wr_data,
   output logic [$clog2(DEPTH):0] o_pending,
   output logic                   o_full
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = ADDR_W + DATA_W;

   sched_state_t   state;
   sched_state_t   state_nxt;
   logic [CW-1:0]  drain_cnt;
   logic [CW-1:0]  drain_cnt_nxt;
   logic           rr_last;
   logic           both;
   logic           grant0;
   logic           grant1;
   logic           push;
   logic           pop;
   logic           empty;
   logic [EW-1:0]  push_data;
   logic [EW-1:0]  head;

   // round-robin: on a tie the port that did not win last time gets the slot
   assign both         = i_req0_valid & i_req1_valid;
   assign o_req0_ready = ~o_full & (~both | rr_last);
   assign o_req1_ready = ~o_full & (~both | ~rr_last);
   assign grant0       = i_req0_valid & o_req0_ready;
   assign grant1       = i_req1_valid & o_req1_ready;
   assign push         = grant0 | grant1;
   assign push_data    = grant0 ? {i_req0_addr, i_req0_data} : {i_req1_addr, i_req1_data};

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (o_full),
      .empty     (empty),
      .count     (o_pending)
   );

   // next-state and pop decision; immediate mode pops from IDLE so an empty queue costs only 2 clocks
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      pop           = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_immediate & ~empty) begin
               pop       = 1'b1;
               state_nxt = ST_IMM;
            end else if (i_vblank_start & ~empty) begin
               state_nxt     = ST_DRAIN;
               drain_cnt_nxt = '0;
            end
         end
         ST_DRAIN: begin
            if (i_vblank & ~empty & (drain_cnt < CW'(DRAIN_MAX))) begin
               pop           = 1'b1;
               drain_cnt_nxt = drain_cnt + CW'(1);
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_IMM: begin
            if (i_immediate & ~empty) pop = 1'b1;
            else                      state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state, drain budget and arbiter history
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         rr_last   <= 1'b1;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (grant0)      rr_last <= 1'b0;
         else if (grant1) rr_last <= 1'b1;
      end
   end

   // register-bank write port: strobe for one clock after a pop, address/data hold otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
      end else begin
         o_wr_en <= pop;
         if (pop) {o_wr_addr, o_wr_data} <= head;
      end
   end

endmodule
